// File: rtl/mem_regfile_gen2.sv
// mem_regfile_gen2: byte-enabled register file with per-register RW/RO/W1C/RWX modes,
// write pulses, read strobes and a 1- or 2-cycle read pipeline.
module mem_regfile_gen2 #(
  parameter int Naddr = 6,
  parameter int Nbits = 32,
  parameter int RD_LAT = 1,
  parameter logic [2**Naddr-1:0][Nbits-1:0] init_reg = '0,
  parameter logic [2**Naddr-1:0][1:0] reg_mode = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [Naddr-1:0]                   addr,
  input  logic                               en,
  input  logic [Nbits/8-1:0]                 we,
  input  logic [Nbits-1:0]                   wr_data,
  output logic [Nbits-1:0]                   rd_data,
  output logic                               rd_valid,
  output logic [2**Naddr-1:0][Nbits-1:0]     reg_val,
  output logic [2**Naddr-1:0][Nbits-1:0]     pul_val,
  output logic [2**Naddr-1:0]                rd_pul,
  input  logic [2**Naddr-1:0][Nbits-1:0]     read_val,
  input  logic [2**Naddr-1:0][Nbits-1:0]     sticky_set
);
  localparam int Nregs = 2**Naddr;
  localparam int Nbytes = Nbits/8;
  logic wr, rd;
  logic [Nbits-1:0] mask, wmask;
  logic [Nregs-1:0] wsel;
  logic [Nregs-1:0][Nbits-1:0] reg_d, reg_q, pul_d, pul_q;
  logic [Nregs-1:0] rd_pul_d, rd_pul_q;
  logic v1_d, v1_q;
  logic [Nbits-1:0] d1_d, d1_q;
  if (!(RD_LAT == 1 || RD_LAT == 2) || (Nbits % 8) != 0) begin : g_bad_param
    $error("mem_regfile_gen2: RD_LAT must be 1 or 2 and Nbits a multiple of 8");
  end
  always_comb begin
    wr = en & |we;
    rd = en & ~|we;
    for (int b = 0; b < Nbytes; b++) mask[b*8 +: 8] = {8{we[b]}};
    wmask = wr_data & mask;
    wsel = wr ? Nregs'(1) << addr : '0;
    rd_pul_d = rd ? Nregs'(1) << addr : '0;
    for (int i = 0; i < Nregs; i++) begin
      pul_d[i] = wsel[i] ? wmask : '0;
      // W1C: set is OR-ed after the clear so a same-cycle set wins
      reg_d[i] = reg_mode[i] == 2'd1 ? '0 :
                 reg_mode[i] == 2'd2 ? (reg_q[i] & ~pul_d[i]) | sticky_set[i] :
                 (reg_q[i] & ~({Nbits{wsel[i]}} & mask)) | pul_d[i];
    end
    v1_d = rd;
    // modes 1 (RO) and 3 (RWX) read back from read_val
    d1_d = rd ? (reg_mode[addr][0] ? read_val[addr] : reg_q[addr]) : d1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Nregs; i++)
        reg_q[i] <= (reg_mode[i] == 2'd0 || reg_mode[i] == 2'd3) ? init_reg[i] : '0;
      pul_q <= '0;
      rd_pul_q <= '0;
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      reg_q <= reg_d;
      pul_q <= pul_d;
      rd_pul_q <= rd_pul_d;
      v1_q <= v1_d;
      d1_q <= d1_d;
    end
  end
  if (RD_LAT == 2) begin : g_lat2
    logic v2_d, v2_q;
    logic [Nbits-1:0] d2_d, d2_q;
    always_comb begin
      v2_d = v1_q;
      d2_d = v1_q ? d1_q : d2_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d2_q <= d2_d;
      end
    end
    assign rd_valid = v2_q;
    assign rd_data = d2_q;
  end else begin : g_lat1
    assign rd_valid = v1_q;
    assign rd_data = d1_q;
  end
  assign reg_val = reg_q;
  assign pul_val = pul_q;
  assign rd_pul = rd_pul_q;
endmodule

// File: tb/tb_mem_regfile_gen2.sv
// tb_mem_regfile_gen2: directed checks of reset, byte writes, modes and the 2-cycle read pipe.
module tb_mem_regfile_gen2;
  function automatic logic [63:0][31:0] mk_init();
    mk_init = '0;
    mk_init[2] = 32'h3333_3030;
    mk_init[6] = 32'h0000_6666;
  endfunction
  function automatic logic [63:0][1:0] mk_mode();
    mk_mode = '0;
    mk_mode[0] = 2'd1;
    mk_mode[5] = 2'd2;
    mk_mode[6] = 2'd3;
  endfunction
  localparam logic [63:0][31:0] INIT = mk_init();
  localparam logic [63:0][1:0] MODE = mk_mode();
  logic clk = 1'b0;
  logic rst, en;
  logic [5:0] addr;
  logic [3:0] we;
  logic [31:0] wr_data, rd_data;
  logic rd_valid;
  logic [63:0][31:0] reg_val, pul_val, read_val, sticky_set;
  logic [63:0] rd_pul;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  mem_regfile_gen2 #(.Naddr(6), .Nbits(32), .RD_LAT(2), .init_reg(INIT), .reg_mode(MODE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .en(en), .we(we), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .reg_val(reg_val), .pul_val(pul_val),
    .rd_pul(rd_pul), .read_val(read_val), .sticky_set(sticky_set));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic acc(input logic e, input logic [3:0] w, input logic [5:0] a, input logic [31:0] d);
    en = e;
    we = w;
    addr = a;
    wr_data = d;
  endtask
  initial begin
    rst = 1'b1;
    acc(0, 0, 0, 0);
    read_val = '0;
    sticky_set = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_reg2", 64'(reg_val[2]), 64'h3333_3030);
    chk("rst_reg6", 64'(reg_val[6]), 64'h0000_6666);
    chk("rst_reg5", 64'(reg_val[5]), 64'h0);
    chk("rst_pul", 64'(|pul_val), 64'h0);
    chk("rst_valid", 64'(rd_valid), 64'h0);
    chk("rst_rdata", 64'(rd_data), 64'h0);
    acc(1, 4'b0101, 2, 32'hAABB_CCDD);
    step();
    acc(0, 0, 0, 0);
    chk("bw_reg2", 64'(reg_val[2]), 64'h33BB_30DD);
    chk("bw_pul2", 64'(pul_val[2]), 64'h00BB_00DD);
    step();
    chk("bw_pul_gone", 64'(|pul_val), 64'h0);
    chk("bw_reg2_hold", 64'(reg_val[2]), 64'h33BB_30DD);
    acc(1, 4'hF, 3, 32'h33);
    step();
    acc(1, 4'hF, 4, 32'h44);
    step();
    acc(1, 0, 2, 0);
    step();
    chk("rp_pul2", rd_pul, 64'h4);
    chk("rp_v_n1", 64'(rd_valid), 64'h0);
    acc(1, 0, 3, 0);
    step();
    chk("rp_pul3", rd_pul, 64'h8);
    chk("rp_v_n2", 64'(rd_valid), 64'h1);
    chk("rp_d2", 64'(rd_data), 64'h33BB_30DD);
    acc(1, 0, 4, 0);
    step();
    chk("rp_pul4", rd_pul, 64'h10);
    chk("rp_v_n3", 64'(rd_valid), 64'h1);
    chk("rp_d3", 64'(rd_data), 64'h33);
    acc(0, 0, 0, 0);
    step();
    chk("rp_pul_off", rd_pul, 64'h0);
    chk("rp_v_n4", 64'(rd_valid), 64'h1);
    chk("rp_d4", 64'(rd_data), 64'h44);
    step();
    chk("rp_v_off", 64'(rd_valid), 64'h0);
    chk("rp_hold", 64'(rd_data), 64'h44);
    acc(1, 4'hF, 3, 32'h5A);
    step();
    acc(1, 0, 3, 0);
    step();
    acc(0, 0, 0, 0);
    step();
    chk("wr_rd_v", 64'(rd_valid), 64'h1);
    chk("wr_rd_d", 64'(rd_data), 64'h5A);
    sticky_set[5] = 32'h11;
    sticky_set[2] = 32'hFFFF_FFFF;
    step();
    sticky_set = '0;
    chk("w1c_set", 64'(reg_val[5]), 64'h11);
    chk("rw_no_sticky", 64'(reg_val[2]), 64'h33BB_30DD);
    acc(1, 4'hF, 5, 32'h01);
    step();
    chk("w1c_clr", 64'(reg_val[5]), 64'h10);
    chk("w1c_pul", 64'(pul_val[5]), 64'h01);
    sticky_set[5] = 32'h10;
    acc(1, 4'hF, 5, 32'h10);
    step();
    sticky_set = '0;
    acc(0, 0, 0, 0);
    chk("w1c_set_wins", 64'(reg_val[5]), 64'h10);
    acc(1, 0, 5, 0);
    sticky_set[5] = 32'h100;
    step();
    sticky_set = '0;
    acc(1, 0, 5, 0);
    step();
    acc(0, 0, 0, 0);
    chk("w1c_rd_old", 64'(rd_data), 64'h10);
    step();
    chk("w1c_rd_new", 64'(rd_data), 64'h110);
    read_val[0] = 32'hDEAD_BEEF;
    read_val[6] = 32'hCAFE_F00D;
    acc(1, 4'hF, 0, 32'h1234);
    step();
    chk("ro_reg", 64'(reg_val[0]), 64'h0);
    chk("ro_pul", 64'(pul_val[0]), 64'h1234);
    acc(1, 0, 0, 0);
    step();
    acc(1, 4'b1100, 6, 32'h1234_5678);
    step();
    chk("ro_rd", 64'(rd_data), 64'hDEAD_BEEF);
    chk("rwx_reg", 64'(reg_val[6]), 64'h1234_6666);
    acc(1, 0, 6, 0);
    step();
    acc(0, 0, 0, 0);
    step();
    chk("rwx_rd", 64'(rd_data), 64'hCAFE_F00D);
    acc(1, 0, 2, 0);
    step();
    acc(0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_valid", 64'(rd_valid), 64'h0);
    chk("mr_rdata", 64'(rd_data), 64'h0);
    chk("mr_reg2", 64'(reg_val[2]), 64'h3333_3030);
    chk("mr_reg5", 64'(reg_val[5]), 64'h0);
    chk("mr_reg6", 64'(reg_val[6]), 64'h0000_6666);
    step();
    chk("mr_valid2", 64'(rd_valid), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
